// File: rtl/spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_arbiter
// Function : Two-requester round-robin arbiter feeding a write-only SPI
//            serialiser (address then data, LSB first, framed by spi_cs).
// Revision : 1.0 - initial release
// ============================================================================
module spi_tx_arbiter #(
    parameter int DSIZE  = 8,
    parameter int CS_GAP = 2
) (
    input  logic             spi_clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [DSIZE-1:0] addr0,
    input  logic [DSIZE-1:0] addr1,
    input  logic [DSIZE-1:0] data0,
    input  logic [DSIZE-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             spi_cs,
    output logic             spi_mosi_out,
    output logic             busy
);

    localparam int               c_CNT_W    = (DSIZE > 1) ? $clog2(DSIZE) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DSIZE - 1);
    localparam logic [3:0]       c_GAP_LAST = 4'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]         r_gap_cnt;
    logic [3:0]         w_gap_nxt;
    logic [DSIZE-1:0]   r_addr;
    logic [DSIZE-1:0]   r_data;
    logic               r_last;
    logic               r_owner;
    logic               w_grant;
    logic               w_winner;
    logic               w_done;
    logic               w_cs_nxt;
    logic               w_mosi_nxt;

    // Serial outputs are registered from the current state, so they trail the
    // state by one cycle: the first address bit leaves two edges after grant.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_grant     = 1'b0;
        w_winner    = 1'b0;
        w_done      = 1'b0;
        w_cs_nxt    = 1'b1;
        w_mosi_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_grant     = 1'b1;
                    w_winner    = (req0 && req1) ? ~r_last : req1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_cs_nxt    = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                w_cs_nxt   = 1'b0;
                w_mosi_nxt = r_addr[r_bit_cnt];
                if (r_bit_cnt == c_LAST_BIT) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            S_DATA: begin
                w_cs_nxt   = 1'b0;
                w_mosi_nxt = r_data[r_bit_cnt];
                if (r_bit_cnt == c_LAST_BIT) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                w_cs_nxt    = 1'b0;
                w_done      = 1'b1;
                w_gap_nxt   = '0;
                w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge spi_clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_last       <= 1'b1;
            r_owner      <= 1'b0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            spi_cs       <= 1'b1;
            spi_mosi_out <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_cnt_nxt;
            r_gap_cnt    <= w_gap_nxt;
            if (w_grant) begin
                r_addr  <= w_winner ? addr1 : addr0;
                r_data  <= w_winner ? data1 : data0;
                r_last  <= w_winner;
                r_owner <= w_winner;
            end
            gnt0         <= w_grant & ~w_winner;
            gnt1         <= w_grant & w_winner;
            done0        <= w_done & ~r_owner;
            done1        <= w_done & r_owner;
            spi_cs       <= w_cs_nxt;
            spi_mosi_out <= w_mosi_nxt;
            busy         <= (w_state_nxt != S_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_tx_arbiter
// Function : Directed self-checking bench for spi_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_tx_arbiter;

    logic       spi_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       req0    = 1'b0;
    logic       req1    = 1'b0;
    logic [7:0] addr0   = '0;
    logic [7:0] addr1   = '0;
    logic [7:0] data0   = '0;
    logic [7:0] data1   = '0;
    logic       gnt0, gnt1, done0, done1, spi_cs, spi_mosi_out, busy;

    int r_checks = 0;
    int r_errors = 0;

    spi_tx_arbiter #(.DSIZE(8), .CS_GAP(2)) u_dut (
        .spi_clk      (spi_clk),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .addr0        (addr0),
        .addr1        (addr1),
        .data0        (data0),
        .data1        (data1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .done0        (done0),
        .done1        (done1),
        .spi_cs       (spi_cs),
        .spi_mosi_out (spi_mosi_out),
        .busy         (busy)
    );

    always #5 spi_clk = ~spi_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge spi_clk);
        #1;
    endtask

    task automatic wait_grant(input logic who);
        int n = 0;
        while (!(gnt0 | gnt1) && n < 30) begin
            tick();
            n++;
        end
        check("gnt_timeout", (n < 30), 1);
        check("gnt_who", gnt1, who);
        check("gnt_excl", gnt0 & gnt1, 0);
    endtask

    // exp[0] is the SETUP cycle, exp[17] the HOLD cycle.
    task automatic check_xfer(input logic [0:17] exp, input logic who,
                              input int late_on, input int late_off);
        for (int i = 0; i < 18; i++) begin
            if (i == late_on)  req1 = 1'b1;
            if (i == late_off) req1 = 1'b0;
            tick();
            check("cs_low", spi_cs, 0);
            check("mosi", spi_mosi_out, exp[i]);
            check("done0", done0, (i == 17) && (who == 1'b0));
            check("done1", done1, (i == 17) && (who == 1'b1));
        end
        tick();
        check("gap_cs", spi_cs, 1);
        check("gap_done", done0 | done1, 0);
        tick();
        check("gap2_cs", spi_cs, 1);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int ng, cyc, last_cyc, overlap, bad;

        // reset state
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_cs", spi_cs, 1);
        check("rst_mosi", spi_mosi_out, 0);
        check("rst_busy", busy, 0);
        check("rst_gnt", {gnt0, gnt1}, 0);
        check("rst_done", {done0, done1}, 0);

        // single transfer, input change after grant, late req1 that drops
        req0 = 1'b1; addr0 = 8'h46; data0 = 8'hA5;
        wait_grant(1'b0);
        check("grant_cs_still_high", spi_cs, 1);
        check("grant_busy", busy, 1);
        req0 = 1'b0; addr0 = 8'hFF; data0 = 8'h00;
        check_xfer(18'b0_01100010_10100101_0, 1'b0, 3, 15);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (gnt1 || busy || !spi_cs) bad++;
        end
        check("late_req_ignored", bad, 0);

        // round robin with both requests held
        reset = 1'b1; tick(); reset = 1'b0;
        addr0 = 8'h11; data0 = 8'h22; addr1 = 8'h33; data1 = 8'h44;
        req0 = 1'b1; req1 = 1'b1;
        ng = 0; cyc = 0; last_cyc = 0; overlap = 0;
        while (ng < 6 && cyc < 300) begin
            tick();
            cyc++;
            if ((gnt0 & gnt1) || (done0 & done1)) overlap++;
            if (gnt0 | gnt1) begin
                check("rr_order", gnt1, ng % 2);
                if (ng > 0) check("rr_period", cyc - last_cyc, 21);
                last_cyc = cyc;
                ng++;
            end
        end
        check("rr_count", ng, 6);
        check("rr_overlap", overlap, 0);
        req0 = 1'b0; req1 = 1'b0;

        // requests ignored while reset is held
        reset = 1'b1; req0 = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (gnt0 || busy) bad++;
        end
        check("rst_hold_ignore", bad, 0);
        reset = 1'b0;

        // reset in ADDR at bit 3
        addr0 = 8'h46; data0 = 8'hA5;
        wait_grant(1'b0);
        req0 = 1'b0;
        tick(); tick(); tick(); tick();
        check("abort_in_addr", spi_cs, 0);
        reset = 1'b1;
        tick();
        check("abort_cs", spi_cs, 1);
        check("abort_busy", busy, 0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done0 || done1 || busy) bad++;
        end
        check("abort_no_resume", bad, 0);

        // fresh req1 served completely
        req1 = 1'b1; addr1 = 8'h3C; data1 = 8'hC3;
        wait_grant(1'b1);
        req1 = 1'b0;
        check_xfer(18'b0_00111100_11000011_0, 1'b1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire
